// File: rtl/uc_sequencer_pkg.sv
// Shared types and constants for the hardwired control unit.
package uc_sequencer_pkg;

  localparam int unsigned DIR_W = 6;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned OPS_W = 8;
  localparam int unsigned PSR_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXEC_ALU = 3'd3,
    LD_WAIT  = 3'd4,
    INCPC    = 3'd5,
    HALT     = 3'd6,
    ERROR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_LD      = 2'd1,
    CLS_HALT    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_e;

  // Register-file addresses; R_ZERO as a C address suppresses the write
  localparam logic [DIR_W-1:0] R_ZERO = 6'd0;
  localparam logic [DIR_W-1:0] R_ONE  = 6'd1;
  localparam logic [DIR_W-1:0] R_PC   = 6'd2;
  localparam logic [DIR_W-1:0] R_IR   = 6'd3;
  localparam logic [DIR_W-1:0] R_OUT  = 6'd4;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;

  localparam logic [1:0]       OP_ALU   = 2'b10;
  localparam logic [OPS_W-1:0] OPS_LD   = 8'hC0;
  localparam logic [OPS_W-1:0] OPS_HALT = 8'h00;

endpackage

// File: rtl/uc_sequencer_decode.sv
// Combinational instruction classifier: {op, op3, i} -> class and ALU code.
module uc_sequencer_decode
  import uc_sequencer_pkg::*;
#(
  parameter int unsigned DATAWIDTH_DECODEROP     = OPS_W,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = ALU_W
) (
  input  logic [DATAWIDTH_DECODEROP-1:0]     ops_i,
  input  logic                               bit13_i,
  output instr_class_e                       class_o,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] alu_code_o
);

  // Classify the opcode; anything not recognised is illegal
  always_comb begin
    class_o    = CLS_ILLEGAL;
    alu_code_o = DATAWIDTH_ALU_SELECTION'({ops_i[4], ops_i[2:0]});
    if (ops_i == DATAWIDTH_DECODEROP'(OPS_HALT)) begin
      class_o = CLS_HALT;
    end else if ((ops_i[7:6] == OP_ALU) && !ops_i[5] && !ops_i[3] && !bit13_i) begin
      class_o = CLS_ALU;
    end else if ((ops_i == DATAWIDTH_DECODEROP'(OPS_LD)) && !bit13_i) begin
      class_o = CLS_LD;
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// Hardwired control unit: fetch/decode/execute/PC-increment sequencing,
// memory req/ack handshake, PSR and sticky error flag.
module uc_sequencer
  import uc_sequencer_pkg::*;
#(
  parameter int unsigned DATAWIDTH_MIR_DIRECTION = DIR_W,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = ALU_W,
  parameter int unsigned DATAWIDTH_DECODEROP     = OPS_W
) (
  input  logic                               UC_SEQUENCER_CLOCK_50,
  input  logic                               UC_SEQUENCER_ResetInLow_In,
  input  logic                               UC_SEQUENCER_Run_In,
  input  logic [DATAWIDTH_DECODEROP-1:0]     UC_SEQUENCER_OPS_InBus,
  input  logic                               UC_SEQUENCER_Bit13_In,
  input  logic                               UC_SEQUENCER_SetCode_In,
  input  logic                               UC_SEQUENCER_FlagN_In,
  input  logic                               UC_SEQUENCER_FlagZ_In,
  input  logic                               UC_SEQUENCER_FlagV_In,
  input  logic                               UC_SEQUENCER_FlagC_In,
  input  logic                               UC_SEQUENCER_MemAck_In,
  output logic [DATAWIDTH_MIR_DIRECTION-1:0] UC_SEQUENCER_DirA_OutBus,
  output logic [DATAWIDTH_MIR_DIRECTION-1:0] UC_SEQUENCER_DirB_OutBus,
  output logic [DATAWIDTH_MIR_DIRECTION-1:0] UC_SEQUENCER_DirC_OutBus,
  output logic                               UC_SEQUENCER_SelectA_Out,
  output logic                               UC_SEQUENCER_SelectB_Out,
  output logic                               UC_SEQUENCER_SelectC_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] UC_SEQUENCER_ALUOperation_OutBus,
  output logic                               UC_SEQUENCER_RD_Out,
  output logic                               UC_SEQUENCER_MemReq_Out,
  output logic [PSR_W-1:0]                   UC_SEQUENCER_PSR_OutBus,
  output logic                               UC_SEQUENCER_Busy_Out,
  output logic                               UC_SEQUENCER_Error_Out
);

  localparam int unsigned AW = DATAWIDTH_MIR_DIRECTION;
  localparam int unsigned LW = DATAWIDTH_ALU_SELECTION;

  state_e            state_q, state_d;
  logic [PSR_W-1:0]  psr_q, psr_d;
  logic              error_q, error_d;

  instr_class_e      dec_class;
  logic [LW-1:0]     dec_alu_code;

  uc_sequencer_decode #(
    .DATAWIDTH_DECODEROP     (DATAWIDTH_DECODEROP),
    .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
  ) u_decode (
    .ops_i      (UC_SEQUENCER_OPS_InBus),
    .bit13_i    (UC_SEQUENCER_Bit13_In),
    .class_o    (dec_class),
    .alu_code_o (dec_alu_code)
  );

  // State, PSR and error registers with synchronous active-low reset
  always_ff @(posedge UC_SEQUENCER_CLOCK_50) begin
    if (!UC_SEQUENCER_ResetInLow_In) begin
      state_q <= IDLE;
      psr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psr_q   <= psr_d;
      error_q <= error_d;
    end
  end

  // Next-state and datapath control; ack-dependent outputs are Mealy
  always_comb begin
    state_d  = state_q;
    psr_d    = psr_q;
    error_d  = error_q;
    UC_SEQUENCER_DirA_OutBus         = '0;
    UC_SEQUENCER_DirB_OutBus         = '0;
    UC_SEQUENCER_DirC_OutBus         = '0;
    UC_SEQUENCER_SelectA_Out         = 1'b0;
    UC_SEQUENCER_SelectB_Out         = 1'b0;
    UC_SEQUENCER_SelectC_Out         = 1'b0;
    UC_SEQUENCER_ALUOperation_OutBus = '0;
    UC_SEQUENCER_RD_Out              = 1'b0;
    UC_SEQUENCER_MemReq_Out          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (UC_SEQUENCER_Run_In) state_d = FETCH;
      end

      FETCH: begin
        UC_SEQUENCER_DirA_OutBus = AW'(R_PC);
        UC_SEQUENCER_DirC_OutBus = AW'(R_ZERO);
        UC_SEQUENCER_MemReq_Out  = 1'b1;
        if (UC_SEQUENCER_MemAck_In) begin
          UC_SEQUENCER_RD_Out      = 1'b1;
          UC_SEQUENCER_DirC_OutBus = AW'(R_IR);
          state_d                  = DECODE;
        end
      end

      DECODE: begin
        unique case (dec_class)
          CLS_HALT: state_d = HALT;
          CLS_ALU:  state_d = EXEC_ALU;
          CLS_LD:   state_d = LD_WAIT;
          default: begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        endcase
      end

      EXEC_ALU: begin
        UC_SEQUENCER_SelectA_Out         = 1'b1;
        UC_SEQUENCER_SelectB_Out         = 1'b1;
        UC_SEQUENCER_SelectC_Out         = 1'b1;
        UC_SEQUENCER_ALUOperation_OutBus = dec_alu_code;
        if (UC_SEQUENCER_SetCode_In) begin
          psr_d = ~{UC_SEQUENCER_FlagN_In, UC_SEQUENCER_FlagZ_In,
                    UC_SEQUENCER_FlagV_In, UC_SEQUENCER_FlagC_In};
        end
        state_d = INCPC;
      end

      LD_WAIT: begin
        // rd select is held off until the ack so it is only written once
        UC_SEQUENCER_SelectA_Out = 1'b1;
        UC_SEQUENCER_DirC_OutBus = AW'(R_ZERO);
        UC_SEQUENCER_MemReq_Out  = 1'b1;
        if (UC_SEQUENCER_MemAck_In) begin
          UC_SEQUENCER_RD_Out      = 1'b1;
          UC_SEQUENCER_SelectC_Out = 1'b1;
          state_d                  = INCPC;
        end
      end

      INCPC: begin
        UC_SEQUENCER_DirA_OutBus         = AW'(R_PC);
        UC_SEQUENCER_DirB_OutBus         = AW'(R_ONE);
        UC_SEQUENCER_DirC_OutBus         = AW'(R_PC);
        UC_SEQUENCER_ALUOperation_OutBus = LW'(ALU_ADD);
        state_d = UC_SEQUENCER_Run_In ? FETCH : IDLE;
      end

      HALT: begin
        state_d = IDLE;
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs
  always_comb begin
    UC_SEQUENCER_PSR_OutBus = psr_q;
    UC_SEQUENCER_Error_Out  = error_q;
    UC_SEQUENCER_Busy_Out   = (state_q != IDLE) && (state_q != ERROR);
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed testbench for uc_sequencer.
module tb_uc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] ops;
  logic       bit13;
  logic       setcode;
  logic       fn, fz, fv, fc;
  logic       ack;
  logic [5:0] dira, dirb, dirc;
  logic       sela, selb, selc;
  logic [3:0] alu;
  logic       rd, req;
  logic [3:0] psr;
  logic       busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uc_sequencer dut (
    .UC_SEQUENCER_CLOCK_50            (clk),
    .UC_SEQUENCER_ResetInLow_In       (rst_n),
    .UC_SEQUENCER_Run_In              (run),
    .UC_SEQUENCER_OPS_InBus           (ops),
    .UC_SEQUENCER_Bit13_In            (bit13),
    .UC_SEQUENCER_SetCode_In          (setcode),
    .UC_SEQUENCER_FlagN_In            (fn),
    .UC_SEQUENCER_FlagZ_In            (fz),
    .UC_SEQUENCER_FlagV_In            (fv),
    .UC_SEQUENCER_FlagC_In            (fc),
    .UC_SEQUENCER_MemAck_In           (ack),
    .UC_SEQUENCER_DirA_OutBus         (dira),
    .UC_SEQUENCER_DirB_OutBus         (dirb),
    .UC_SEQUENCER_DirC_OutBus         (dirc),
    .UC_SEQUENCER_SelectA_Out         (sela),
    .UC_SEQUENCER_SelectB_Out         (selb),
    .UC_SEQUENCER_SelectC_Out         (selc),
    .UC_SEQUENCER_ALUOperation_OutBus (alu),
    .UC_SEQUENCER_RD_Out              (rd),
    .UC_SEQUENCER_MemReq_Out          (req),
    .UC_SEQUENCER_PSR_OutBus          (psr),
    .UC_SEQUENCER_Busy_Out            (busy),
    .UC_SEQUENCER_Error_Out           (err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pack all control outputs: {dira, dirb, dirc, sela, selb, selc, alu, rd, req}
  function automatic logic [31:0] ctrl_pack(input logic [5:0] a, input logic [5:0] b,
                                            input logic [5:0] c, input logic sa,
                                            input logic sb, input logic sc,
                                            input logic [3:0] op, input logic r,
                                            input logic q);
    return 32'({a, b, c, sa, sb, sc, op, r, q});
  endfunction

  task automatic chk_ctrl(input string tag, input logic [31:0] exp);
    chk(tag, ctrl_pack(dira, dirb, dirc, sela, selb, selc, alu, rd, req), exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  logic [31:0] c_idle, c_fetch, c_fetch_ack, c_exec8, c_incpc, c_ldw;

  initial begin
    c_idle      = ctrl_pack(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    c_fetch     = ctrl_pack(6'd2, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    c_fetch_ack = ctrl_pack(6'd2, 6'd0, 6'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    c_exec8     = ctrl_pack(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
    c_incpc     = ctrl_pack(6'd2, 6'd1, 6'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    c_ldw       = ctrl_pack(6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    rst_n = 1'b0; run = 1'b1; ops = 8'h00; bit13 = 1'b0; setcode = 1'b0;
    fn = 1'b1; fz = 1'b1; fv = 1'b1; fc = 1'b1; ack = 1'b0;

    // Reset held two cycles with Run high
    tick;
    chk_ctrl("rst1_ctrl", c_idle);
    chk("rst1_busy", 32'(busy), 32'd0);
    tick;
    chk_ctrl("rst2_ctrl", c_idle);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_psr", 32'(psr), 32'd0);
    rst_n = 1'b1;

    // Fetch with three wait cycles
    tick;
    chk("busy_after_rel", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk_ctrl($sformatf("fetch_wait%0d", i), c_fetch);
      tick;
    end
    ack = 1'b1; ops = 8'h90; bit13 = 1'b0;
    settle;
    chk_ctrl("fetch_ack", c_fetch_ack);
    tick;
    ack = 1'b0;
    settle;
    chk_ctrl("decode_addcc", c_idle);

    // addcc execute and PSR update
    tick;
    setcode = 1'b1; fz = 1'b0;
    settle;
    chk_ctrl("exec_addcc", c_exec8);
    chk("psr_before", 32'(psr), 32'd0);
    tick;
    setcode = 1'b0; fz = 1'b1;
    settle;
    chk_ctrl("incpc_addcc", c_incpc);
    chk("psr_addcc", 32'(psr), 32'b0100);

    // ld with one wait cycle
    tick;
    ack = 1'b1; ops = 8'hC0;
    settle;
    chk_ctrl("fetch_ld", c_fetch_ack);
    tick;
    ack = 1'b0;
    settle;
    chk_ctrl("decode_ld", c_idle);
    tick;
    chk_ctrl("ld_wait", c_ldw);
    tick;
    ack = 1'b1;
    settle;
    chk("ld_ack_sela", 32'(sela), 32'd1);
    chk("ld_ack_req", 32'(req), 32'd1);
    chk("ld_ack_rd", 32'(rd), 32'd1);
    chk("ld_ack_selc", 32'(selc), 32'd1);
    chk("ld_ack_selb", 32'(selb), 32'd0);
    tick;
    ack = 1'b0;
    settle;
    chk_ctrl("incpc_ld", c_incpc);
    chk("psr_kept", 32'(psr), 32'b0100);

    // halt: IDLE two cycles after DECODE, no PC write
    tick;
    ack = 1'b1; ops = 8'h00;
    settle;
    chk_ctrl("fetch_halt", c_fetch_ack);
    tick;
    ack = 1'b0; run = 1'b0;
    settle;
    chk_ctrl("decode_halt", c_idle);
    tick;
    chk_ctrl("halt_ctrl", c_idle);
    chk("halt_busy", 32'(busy), 32'd1);
    tick;
    chk("idle_busy", 32'(busy), 32'd0);
    tick;
    chk("idle_stay", 32'(busy), 32'd0);

    // Reset during LD_WAIT, late ack ignored
    run = 1'b1;
    tick;
    ack = 1'b1; ops = 8'hC0;
    settle;
    chk_ctrl("fetch_ld2", c_fetch_ack);
    tick;
    ack = 1'b0;
    tick;
    chk_ctrl("ld_wait2", c_ldw);
    rst_n = 1'b0;
    tick;
    chk_ctrl("ld_reset_ctrl", c_idle);
    chk("ld_reset_busy", 32'(busy), 32'd0);
    chk("ld_reset_psr", 32'(psr), 32'd0);
    rst_n = 1'b1; run = 1'b0;
    tick;
    ack = 1'b1;
    settle;
    chk_ctrl("late_ack", c_idle);
    tick;
    ack = 1'b0;
    settle;
    chk_ctrl("after_late_ack", c_idle);
    chk("after_late_busy", 32'(busy), 32'd0);

    // Illegal instruction -> sticky ERROR
    run = 1'b1;
    tick;
    ack = 1'b1; ops = 8'h80; bit13 = 1'b1;
    settle;
    chk_ctrl("fetch_ill", c_fetch_ack);
    tick;
    ack = 1'b0;
    settle;
    chk("decode_ill_err", 32'(err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick;
      ack = (i % 2 == 1);
      settle;
      chk($sformatf("err_hold%0d", i), 32'({err, req, busy}), 32'b100);
    end
    ack = 1'b0;
    rst_n = 1'b0;
    tick;
    chk("err_cleared", 32'(err), 32'd0);
    chk_ctrl("err_rst_ctrl", c_idle);
    rst_n = 1'b1; run = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
